manta_bus_arbiter: RTL and testbench
====================================

// Module: manta_bus_arbiter
// PURPOSE
//  Shares one Manta register bus (16b addr/16b data/rw/valid core chain) among N_REQ
//  masters, e.g. bridge_rx plus on-chip sequencers. Round-robin grant, one transaction
//  in flight. Routes the chain's returned read/write echo back to the owning master.
//  Timeout guards against addresses that no core answers.
//  Sits between the masters and the first core's input port. The last core's output
//  port feeds bus_*_i.
// PARAMETERS
//  N_REQ    2    number of requesting masters (1..8)
//  TIMEOUT  255  cycles to wait in WAIT for a bus echo before an error response (>=4)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous reset, active-high
//  req_valid_i  in   N_REQ    master m requests; held until req_ready_o[m]
//  req_addr_i   in   16*N_REQ master m address, slice [16m+15:16m]
//  req_data_i   in   16*N_REQ master m write data
//  req_rw_i     in   N_REQ    1=write, 0=read
//  req_ready_o  out  N_REQ    one-cycle accept pulse, at most one bit set
//  rsp_valid_o  out  N_REQ    one-cycle completion pulse to the owning master
//  rsp_data_o   out  16       read data (echoed data for writes), valid with rsp_valid_o
//  rsp_err_o    out  1        1 = completion caused by timeout
//  bus_addr_o   out  16       shared bus address to core chain
//  bus_data_o   out  16       shared bus write data
//  bus_rw_o     out  1        shared bus rw
//  bus_valid_o  out  1        single-cycle transaction strobe
//  bus_data_i   in   16       data returned at end of core chain
//  bus_rw_i     in   1        rw returned at end of core chain
//  bus_valid_i  in   1        echo strobe from end of core chain
// BEHAVIOUR
//  - All outputs registered. Reset: all outputs 0, state IDLE, rr pointer = 0
//    (master 0 highest priority), timer 0, owner 0.
//  - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE, cycle T, any req_valid_i set:
//    - grant g = first set bit searching from ptr upward, with wrap.
//    - latch g and its addr/data/rw.
//    - go to ISSUE.
//  - ISSUE, cycle T+1:
//    - bus_valid_o=1 with latched fields; req_ready_o[g]=1.
//    - timer cleared; go to WAIT.
//    - bus_* fields return to 0 the following cycle.
//  - WAIT:
//    - timer increments each cycle.
//    - bus_valid_i=1: rsp_valid_o[g]=1, rsp_data_o=bus_data_i, rsp_err_o=0 next cycle.
//    - timer==TIMEOUT-1 with no echo: rsp_valid_o[g]=1, rsp_data_o=0, rsp_err_o=1.
//    - either completion: ptr=(g+1) mod N_REQ, state IDLE.
//    - echo and timeout in the same cycle: echo wins, err=0.
//  - Minimum turnaround with 1 core (1-cycle latency):
//    accept T, strobe T+1, echo T+2, rsp T+3, next strobe T+5.
//  - bus_valid_i while IDLE or ISSUE (late or stray echo): ignored, never routed.
//  - Masters dropping req_valid_i before being granted is legal and causes no grant.
//  - Requests arriving during ISSUE/WAIT wait; no skid storage.
//  - Reset mid-WAIT: everything returns to reset values, no rsp pulse.
//    The later echo is ignored per the stray rule.
//  - bus_rw_i is not checked; the response takes the data of whichever echo arrives first.
//  - Fairness: a continuously requesting master is granted within N_REQ transactions.
// STRUCTURE
//  - manta_bus_pkg: ADDR_W=16, DATA_W=16, typedef struct {addr,data,rw} bus_req_t,
//    typedef enum {IDLE,ISSUE,WAIT} arb_state_t.
//  - Sub-module rr_arbiter #(N): combinational.
//    Inputs req[N] and ptr. Outputs onehot grant and grant_idx.
//  - The top holds the FSM, latches, timer and response routing.
// TESTING
//  1. N_REQ=2, master0 read 0x0003, core returns 0x1234:
//     ready0 pulse, bus strobe addr 3 rw 0, rsp_valid[0], data 0x1234, err 0.
//  2. Both request every cycle:
//     grants alternate 0,1,0,1. Strobes spaced >= 4 cycles. No double grant.
//  3. Master1 write 0x0005 <- 0xBEEF:
//     bus strobe rw=1 data 0xBEEF. rsp_valid[1] after the echo, data 0xBEEF.
//  4. No core answers, TIMEOUT=8: rsp_valid[g] with err=1 and data 0 exactly 8 cycles
//     after the strobe. The echo then injected in IDLE is ignored.
//  5. Assert rst 2 cycles after the strobe: outputs 0. The late echo produces no rsp.
//     The next request goes to master 0.
//  6. Echo in the exact timeout cycle: err=0, data = echo data.

Source files
------------

// File: rtl/manta_bus_pkg.sv
// Shared types and widths for the Manta register-bus arbiter.
package manta_bus_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              rw;
   } bus_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/manta_bus_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Walk the requests starting at ptr and stop at the first one set.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IDX_W'((32'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/manta_bus_arbiter.sv
// Round-robin arbiter sharing one Manta core chain among N_REQ masters,
// one transaction in flight, with an echo timeout.
module manta_bus_arbiter
   import manta_bus_pkg::*;
#(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [ADDR_W*N_REQ-1:0] req_addr_i,
   input  logic [DATA_W*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]        req_rw_i,
   output logic [N_REQ-1:0]        req_ready_o,
   output logic [N_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]       rsp_data_o,
   output logic                    rsp_err_o,
   output logic [ADDR_W-1:0]       bus_addr_o,
   output logic [DATA_W-1:0]       bus_data_o,
   output logic                    bus_rw_o,
   output logic                    bus_valid_o,
   input  logic [DATA_W-1:0]       bus_data_i,
   input  logic                    bus_rw_i,
   input  logic                    bus_valid_i
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant;
   logic [TMR_W-1:0] timer;
   bus_req_t         sel;
   logic             unused_bus_rw;

   // The echoed rw is not checked; the first echo completes the transaction.
   assign unused_bus_rw = bus_rw_i;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req       (req_valid_i),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Mux out the fields of the master chosen by the arbiter.
   always_comb begin
      sel = '0;
      for (int unsigned m = 0; m < N_REQ; m++) begin
         if (grant_idx == IDX_W'(m)) begin
            sel.addr = req_addr_i[m*ADDR_W +: ADDR_W];
            sel.data = req_data_i[m*DATA_W +: DATA_W];
            sel.rw   = req_rw_i[m];
         end
      end
   end

   // Transaction FSM: grant, issue the strobe, wait for echo or timeout.
   // Timer value equals cycles elapsed since the strobe cycle.
   // No grant in the cycle a response is presented, so the owner sees its
   // completion before re-arbitration starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         timer       <= '0;
         req_ready_o <= '0;
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         bus_addr_o  <= '0;
         bus_data_o  <= '0;
         bus_rw_o    <= 1'b0;
         bus_valid_o <= 1'b0;
      end else begin
         req_ready_o <= '0;
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         bus_addr_o  <= '0;
         bus_data_o  <= '0;
         bus_rw_o    <= 1'b0;
         bus_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if ((|req_valid_i) && !(|rsp_valid_o)) begin
                  owner       <= grant_idx;
                  timer       <= '0;
                  req_ready_o <= grant;
                  bus_addr_o  <= sel.addr;
                  bus_data_o  <= sel.data;
                  bus_rw_o    <= sel.rw;
                  bus_valid_o <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= timer + TMR_W'(1);
               state <= WAIT;
            end
            WAIT: begin
               if (bus_valid_i) begin
                  rsp_valid_o <= N_REQ'(1) << owner;
                  rsp_data_o  <= bus_data_i;
                  ptr         <= IDX_W'((32'(owner) + 32'd1) % N_REQ);
                  state       <= IDLE;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  rsp_valid_o <= N_REQ'(1) << owner;
                  rsp_err_o   <= 1'b1;
                  ptr         <= IDX_W'((32'(owner) + 32'd1) % N_REQ);
                  state       <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Self-checking bench for manta_bus_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_manta_bus_arbiter;
   import manta_bus_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [16*N-1:0] req_addr;
   logic [16*N-1:0] req_data;
   logic [N-1:0]    req_rw;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [15:0]     rsp_data;
   logic            rsp_err;
   logic [15:0]     bus_addr;
   logic [15:0]     bus_data;
   logic            bus_rw;
   logic            bus_valid;
   logic [15:0]     echo_data;
   logic            echo_rw;
   logic            echo_valid;

   always #5 clk = ~clk;

   manta_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_rw_i    (req_rw),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err),
      .bus_addr_o  (bus_addr),
      .bus_data_o  (bus_data),
      .bus_rw_o    (bus_rw),
      .bus_valid_o (bus_valid),
      .bus_data_i  (echo_data),
      .bus_rw_i    (echo_rw),
      .bus_valid_i (echo_valid)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Core-chain model: 16-word memory, programmable echo latency (0 = silent).
   logic [15:0] core_mem [16];
   int          core_cnt   = -1;
   logic [15:0] core_q     = '0;
   logic        core_rw_q  = 1'b0;
   int          core_lat   = 1;
   bit          core_rand  = 1'b0;
   int          last_lat   = 1;
   int          stray_at   = -1;
   logic [15:0] stray_data = '0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endfunction

   function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < int'(N); k++) begin
         int m;
         m = (ptr + k) % int'(N);
         if (p[m]) return m;
      end
      return -1;
   endfunction

   task automatic set_req(input int m, input logic v, input logic rw, input logic [15:0] a, input logic [15:0] d);
      req_valid[m]        = v;
      req_rw[m]           = rw;
      req_addr[m*16 +: 16] = a;
      req_data[m*16 +: 16] = d;
   endtask

   // Advance one cycle; sample point is 1 time unit after the edge.
   task automatic tick();
      int unsigned r;
      int lat;
      @(posedge clk);
      #1;
      cyc++;
      echo_valid = 1'b0;
      echo_data  = '0;
      echo_rw    = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            echo_valid = 1'b1;
            echo_data  = core_q;
            echo_rw    = core_rw_q;
            core_cnt   = -1;
         end
      end
      if (stray_at == cyc) begin
         echo_valid = 1'b1;
         echo_data  = stray_data;
      end
      if (bus_valid) begin
         if (bus_rw) core_mem[bus_addr[3:0]] = bus_data;
         core_q    = bus_rw ? bus_data : core_mem[bus_addr[3:0]];
         core_rw_q = bus_rw;
         if (core_rand) begin
            r = $urandom_range(0, 7);
            if (r == 0)      lat = 0;
            else if (r == 1) lat = int'(TO) - 1;
            else             lat = 1 + int'(r % 3);
            if (lat == 0) begin
               stray_at   = cyc + int'(TO) + int'($urandom_range(0, 1));
               stray_data = 16'hBAD0;
            end
         end else begin
            lat = core_lat;
         end
         last_lat = lat;
         core_cnt = (lat == 0) ? -1 : lat;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_bus"}, 32'({bus_addr, bus_data}), 32'd0);
      check({tag, "_ctl"}, 32'({req_ready, rsp_valid, rsp_err, bus_rw, bus_valid, rsp_data}), 32'd0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_data  = '0;
      tick();
      tick();
      check_zero_outputs("reset");
      rst = 1'b0;
   endtask

   typedef struct {
      int          m;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] exp_data;
      logic        exp_err;
      int          exp_dly;
   } vec_t;

   vec_t vecs [6];

   // One directed transaction: strobe fields, response timing, data and error.
   task automatic run_vec(input vec_t v, input string tag);
      bit           seen;
      int           s_cyc;
      int           r_cyc;
      logic [N-1:0] oh;
      logic [N-1:0] r_valid;
      logic [15:0]  r_data;
      logic         r_err;
      oh        = '0;
      oh[v.m]   = 1'b1;
      core_rand = 1'b0;
      core_lat  = v.lat;
      set_req(v.m, 1'b1, v.rw, v.addr, v.wdata);
      seen  = 1'b0;
      s_cyc = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (bus_valid) begin
            seen  = 1'b1;
            s_cyc = cyc;
            check({tag, "_ready"}, 32'(req_ready), 32'(oh));
            check({tag, "_addr"}, 32'(bus_addr), 32'(v.addr));
            check({tag, "_rw"}, 32'(bus_rw), 32'(v.rw));
            if (v.rw) check({tag, "_wdata"}, 32'(bus_data), 32'(v.wdata));
         end
      end
      check({tag, "_strobe_seen"}, 32'(seen), 32'd1);
      set_req(v.m, 1'b0, 1'b0, 16'h0000, 16'h0000);
      seen    = 1'b0;
      r_cyc   = 0;
      r_valid = '0;
      r_data  = '0;
      r_err   = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (|rsp_valid) begin
            seen    = 1'b1;
            r_cyc   = cyc;
            r_valid = rsp_valid;
            r_data  = rsp_data;
            r_err   = rsp_err;
         end
      end
      check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_rsp_delay"}, 32'(r_cyc - s_cyc), 32'(v.exp_dly));
         check({tag, "_rsp_owner"}, 32'(r_valid), 32'(oh));
         check({tag, "_rsp_data"}, 32'(r_data), 32'(v.exp_data));
         check({tag, "_rsp_err"}, 32'(r_err), 32'(v.exp_err));
      end
      if (v.lat == 0) begin
         stray_at   = cyc + 1;
         stray_data = 16'hDEAD;
         repeat (4) begin
            tick();
            check({tag, "_stray_ignored"}, 32'(rsp_valid), 32'd0);
         end
      end
      tick();
      tick();
   endtask

   // Random-phase model state
   logic [N-1:0] pend;
   logic [15:0]  p_addr [N];
   logic [15:0]  p_data [N];
   logic         p_rw   [N];
   logic [15:0]  mm     [16];

   initial begin
      int          exp_m;
      int          last;
      int          nstrobe;
      int          s_cyc;
      bit          seen;
      int          free_from;
      int          exp_strobe_cyc;
      int          exp_rsp_cyc;
      int          exp_g;
      int          own;
      int          ptr_m;
      int          n_grants;
      bit          strobe_exp;
      bit          rsp_exp;
      logic [15:0] exp_rd;
      logic        exp_er;

      rst        = 1'b1;
      echo_valid = 1'b0;
      echo_data  = '0;
      echo_rw    = 1'b0;
      for (int i = 0; i < 16; i++) core_mem[i] = '0;
      core_mem[3] = 16'h1234;

      vecs[0] = '{0, 1'b0, 16'h0003, 16'h0000, 1, 16'h1234, 1'b0, 2};
      vecs[1] = '{1, 1'b1, 16'h0005, 16'hBEEF, 1, 16'hBEEF, 1'b0, 2};
      vecs[2] = '{1, 1'b0, 16'h0005, 16'h0000, 2, 16'hBEEF, 1'b0, 3};
      vecs[3] = '{0, 1'b0, 16'h0009, 16'h0000, 0, 16'h0000, 1'b1, 8};
      vecs[4] = '{1, 1'b0, 16'h0003, 16'h0000, 7, 16'h1234, 1'b0, 8};
      vecs[5] = '{0, 1'b1, 16'h000A, 16'h0F0F, 3, 16'h0F0F, 1'b0, 4};

      do_reset();
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Both masters request continuously: strict alternation, 4-cycle strobe spacing.
      do_reset();
      core_rand = 1'b0;
      core_lat  = 1;
      set_req(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
      set_req(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
      exp_m   = 0;
      last    = -1;
      nstrobe = 0;
      for (int k = 0; k < 60 && nstrobe < 8; k++) begin
         tick();
         check("t2_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         if (bus_valid) begin
            check("t2_grant", 32'(req_ready), 32'd1 << exp_m);
            check("t2_addr", 32'(bus_addr), 32'(exp_m + 1));
            if (last >= 0) check("t2_gap", 32'(cyc - last), 32'd4);
            last  = cyc;
            exp_m = 1 - exp_m;
            nstrobe++;
         end
      end
      check("t2_strobes", 32'(nstrobe), 32'd8);
      req_valid = '0;
      repeat (6) tick();

      // Reset two cycles into WAIT: outputs clear, late echo ignored, ptr back to 0.
      do_reset();
      run_vec(vecs[0], "t5pre");
      core_lat = 4;
      set_req(1, 1'b1, 1'b0, 16'h0007, 16'h0000);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (bus_valid) seen = 1'b1;
      end
      check("t5_strobe_seen", 32'(seen), 32'd1);
      set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_zero_outputs("t5_async");
      tick();
      check_zero_outputs("t5_held");
      rst = 1'b0;
      repeat (6) begin
         tick();
         check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end
      core_lat = 1;
      set_req(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
      set_req(1, 1'b1, 1'b0, 16'h0022, 16'h0000);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (bus_valid) begin
            seen = 1'b1;
            check("t5_first_grant", 32'(req_ready), 32'd1);
            check("t5_first_addr", 32'(bus_addr), 32'h0011);
         end
      end
      check("t5_grant_seen", 32'(seen), 32'd1);
      req_valid = '0;
      repeat (6) tick();

      // Randomized traffic against the transaction-level model.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         core_mem[i] = 16'(i * 16'h1111);
         mm[i]       = 16'(i * 16'h1111);
      end
      for (int m = 0; m < int'(N); m++) begin
         p_addr[m] = '0;
         p_data[m] = '0;
         p_rw[m]   = 1'b0;
      end
      core_rand      = 1'b1;
      pend           = '0;
      free_from      = cyc;
      exp_strobe_cyc = -1;
      exp_rsp_cyc    = -1;
      exp_g          = 0;
      own            = 0;
      ptr_m          = 0;
      n_grants       = 0;
      exp_rd         = '0;
      exp_er         = 1'b0;
      repeat (3000) begin
         tick();
         strobe_exp = (cyc == exp_strobe_cyc);
         check("r_bus_valid", 32'(bus_valid), 32'(strobe_exp));
         check("r_ready", 32'(req_ready), strobe_exp ? (32'd1 << exp_g) : 32'd0);
         if (strobe_exp) begin
            check("r_addr", 32'(bus_addr), 32'(p_addr[exp_g]));
            check("r_rw", 32'(bus_rw), 32'(p_rw[exp_g]));
            check("r_wdata", 32'(bus_data), 32'(p_data[exp_g]));
            if (p_rw[exp_g]) begin
               mm[p_addr[exp_g][3:0]] = p_data[exp_g];
               exp_rd = p_data[exp_g];
            end else begin
               exp_rd = mm[p_addr[exp_g][3:0]];
            end
            own         = exp_g;
            pend[exp_g] = 1'b0;
            n_grants++;
            if (last_lat == 0) begin
               exp_rsp_cyc = cyc + int'(TO);
               exp_rd      = '0;
               exp_er      = 1'b1;
            end else begin
               exp_rsp_cyc = cyc + last_lat + 1;
               exp_er      = 1'b0;
            end
            free_from = exp_rsp_cyc + 1;
         end
         rsp_exp = (cyc == exp_rsp_cyc);
         check("r_rsp_valid", 32'(rsp_valid), rsp_exp ? (32'd1 << own) : 32'd0);
         if (rsp_exp) begin
            check("r_rsp_data", 32'(rsp_data), 32'(exp_rd));
            check("r_rsp_err", 32'(rsp_err), 32'(exp_er));
            ptr_m = (own + 1) % int'(N);
         end
         for (int m = 0; m < int'(N); m++) begin
            if (pend[m]) begin
               if ($urandom_range(0, 15) == 0) pend[m] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               pend[m]   = 1'b1;
               p_addr[m] = 16'($urandom);
               p_data[m] = 16'($urandom);
               p_rw[m]   = 1'($urandom_range(0, 1));
            end
            set_req(m, pend[m], p_rw[m], p_addr[m], p_data[m]);
         end
         if (cyc >= free_from && pend != '0) begin
            exp_g          = rr_pick(pend, ptr_m);
            exp_strobe_cyc = cyc + 1;
            free_from      = 32'h3FFF_FFFF;
         end
      end
      req_valid = '0;
      check("r_enough_grants", 32'(n_grants >= 100), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
